// File: rtl/dyn_adder_seq.sv
// Segmented sequential adder: carries ripple one segment per clock, and completion is predicted
// from the longest run of full-propagate segments so short carry chains finish early.
module dyn_adder_seq #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SEGMENTS = 4,
  parameter int unsigned LAT_W    = $clog2(SEGMENTS + 2)
) (
  input  logic             adder_clk,
  input  logic             adder_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             fixed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [LAT_W-1:0] latency
);

  localparam int unsigned SegW = WIDTH / SEGMENTS;

  if (WIDTH % SEGMENTS != 0) begin : g_bad_seg
    $error("WIDTH must be a multiple of SEGMENTS");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic                fixed_q;
  logic [SEGMENTS-1:0] c_q;
  logic [LAT_W-1:0]    cnt_q;
  logic                first_q;
  logic [WIDTH-1:0]    sum_q;
  logic                cout_q;
  logic [LAT_W-1:0]    lat_q;
  logic                in_ready_q, out_valid_q;

  logic [WIDTH-1:0]    sum_c;
  logic [SEGMENTS-1:0] co_c, init_co, p_c;
  logic [LAT_W-1:0]    lat_c, remain;

  always_comb begin
    logic [SegW:0] t;
    logic [SegW:0] u;
    int            run;
    int            best;
    sum_c   = '0;
    co_c    = '0;
    init_co = '0;
    p_c     = '0;
    t       = '0;
    u       = '0;
    run     = 0;
    best    = 0;
    for (int j = 0; j < int'(SEGMENTS); j++) begin
      t = {1'b0, a_q[j*SegW +: SegW]} + {1'b0, b_q[j*SegW +: SegW]}
          + {{SegW{1'b0}}, c_q[j]};
      sum_c[j*SegW +: SegW] = t[SegW-1:0];
      co_c[j]               = t[SegW];
      // Carries seeded at accept: correct for every segment not fed by a propagate run.
      u = {1'b0, a[j*SegW +: SegW]} + {1'b0, b[j*SegW +: SegW]}
          + {{SegW{1'b0}}, (j == 0) ? cin : 1'b0};
      init_co[j] = u[SegW];
      p_c[j]     = &(a_q[j*SegW +: SegW] ^ b_q[j*SegW +: SegW]);
      if (p_c[j]) run = run + 1;
      else        run = 0;
      if (run > best) best = run;
    end
    if (fixed_q) lat_c = LAT_W'(SEGMENTS + 1);
    else         lat_c = LAT_W'(best + 1);
  end

  // The down-counter is loaded with the predicted latency on the first busy cycle.
  assign remain = first_q ? lat_c : cnt_q;

  always_ff @(posedge adder_clk) begin
    if (!adder_rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      fixed_q     <= 1'b0;
      c_q         <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      lat_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            fixed_q <= fixed_mode;
            c_q[0]  <= cin;
            for (int j = 1; j < int'(SEGMENTS); j++) c_q[j] <= init_co[j-1];
            first_q    <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          for (int j = 1; j < int'(SEGMENTS); j++) c_q[j] <= co_c[j-1];
          first_q <= 1'b0;
          if (remain == LAT_W'(1)) begin
            sum_q       <= sum_c;
            cout_q      <= co_c[SEGMENTS-1];
            lat_q       <= lat_c;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= remain - LAT_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            lat_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign latency   = lat_q;

endmodule

// File: tb/tb_dyn_adder_seq.sv
// Directed and randomised checks of dyn_adder_seq results, latency prediction and handshake.
module tb_dyn_adder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, fixed_mode, out_valid, out_ready, cout;
  logic [31:0] a, b, sum;
  logic [2:0]  latency;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dyn_adder_seq #(.WIDTH(32), .SEGMENTS(4)) dut (
    .adder_clk  (clk),
    .adder_rst_n(rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .fixed_mode (fixed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .latency    (latency)
  );

  function automatic int model_lat(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mf);
    logic [31:0] x;
    int run, best;
    if (mf) return 5;
    x = ma ^ mb;
    run = 0;
    best = 0;
    for (int j = 0; j < 4; j++) begin
      if (x[j*8 +: 8] == 8'hFF) run++;
      else run = 0;
      if (run > best) best = run;
    end
    return best + 1;
  endfunction

  // Accepts one operation and waits (bounded) for out_valid; edges counts edges after accept.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                        input logic tf, input bit junk, output int edges);
    a = ta; b = tb_; cin = tc; fixed_mode = tf; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = junk;
    edges = 0;
    for (int k = 0; k < 20; k++) begin
      if (junk) begin a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); end
      @(posedge clk); #1;
      edges++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if ({cout, sum, latency} !== 36'h0) begin n_bad++; $display("FAIL reset_outputs got %h/%b/%0d want 0", sum, cout, latency); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                               input logic tc, input logic [31:0] es, input logic ec,
                               input int el);
    int e;
    run_op(ta, tb_, tc, 1'b0, 1'b0, e);
    n_cmp++; if (e != el) begin n_bad++; $display("FAIL %s_edges got %0d want %0d", nm, e, el); end
    n_cmp++; if (sum !== es) begin n_bad++; $display("FAIL %s_sum got %h want %h", nm, sum, es); end
    n_cmp++; if (cout !== ec) begin n_bad++; $display("FAIL %s_cout got %b want %b", nm, cout, ec); end
    n_cmp++; if (latency !== 3'(el)) begin n_bad++; $display("FAIL %s_latency got %0d want %0d", nm, latency, el); end
    consume();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_bad++; $display("FAIL %s_release got rdy=%b vld=%b want rdy=1 vld=0", nm, in_ready, out_valid); end
    n_cmp++; if ({cout, sum, latency} !== 36'h0) begin n_bad++; $display("FAIL %s_cleared got %h/%b/%0d want 0", nm, sum, cout, latency); end
  endtask

  task automatic test_fixed_hold();
    int e;
    run_op(32'h1, 32'h1, 1'b0, 1'b1, 1'b0, e);
    n_cmp++; if (e != 5) begin n_bad++; $display("FAIL fixed_edges got %0d want 5", e); end
    n_cmp++; if (latency !== 3'd5) begin n_bad++; $display("FAIL fixed_latency got %0d want 5", latency); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({in_ready, out_valid, sum, latency} !== {2'b01, 32'h2, 3'd5}) begin
        n_bad++;
        $display("FAIL fixed_hold cyc %0d got rdy=%b vld=%b sum=%h lat=%0d want rdy=0 vld=1 sum=2 lat=5",
                 k, in_ready, out_valid, sum, latency);
      end
    end
    consume();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fixed_release got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_op();
    int e;
    a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; fixed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_bad++; $display("FAIL midrst_state got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); end
    n_cmp++; if ({sum, latency} !== 35'h0) begin n_bad++; $display("FAIL midrst_outputs got %h/%0d want 0", sum, latency); end
    run_op(32'd5, 32'd7, 1'b0, 1'b0, 1'b0, e);
    n_cmp++; if (sum !== 32'hC) begin n_bad++; $display("FAIL midrst_sum got %h want 0000000c", sum); end
    n_cmp++; if (latency !== 3'd1 || e != 1) begin n_bad++; $display("FAIL midrst_latency got %0d/%0d want 1", latency, e); end
    consume();
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, m;
    logic        rc;
    logic [32:0] exp_v;
    int          el, e, stall;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rc = 1'($urandom_range(0, 1));
      // Bias toward long propagate runs by forcing chosen bytes to a^b = FF.
      m = {{8{1'($urandom_range(0, 1))}}, {8{1'($urandom_range(0, 1))}},
           {8{1'($urandom_range(0, 1))}}, {8{1'($urandom_range(0, 1))}}};
      rb = (~ra & m) | ($urandom & ~m);
      exp_v = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      el = model_lat(ra, rb, 1'b0);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rnd_ready op %0d got 0 want 1", i); end
      run_op(ra, rb, rc, 1'b0, 1'b1, e);
      n_cmp++;
      if ({cout, sum} !== exp_v || latency !== 3'(el) || e != el) begin
        n_bad++;
        $display("FAIL rnd_result a=%h b=%h c=%b got %b_%h lat=%0d edges=%0d want %b_%h lat=%0d",
                 ra, rb, rc, cout, sum, latency, e, exp_v[32], exp_v[31:0], el);
      end
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp_v) begin
          n_bad++;
          $display("FAIL rnd_stall op %0d got vld=%b rdy=%b sum=%h", i, out_valid, in_ready, sum);
        end
      end
      consume();
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; fixed_mode = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed("simple", 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1);
    test_directed("full_chain", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 5);
    test_directed("mid_run", 32'h00FF_FF00, 32'h0, 1'b0, 32'h00FF_FF00, 1'b0, 3);
    test_fixed_hold();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
